// File: rtl/dvs_filter_pkg.sv
// Shared types and helpers for the DVS background-activity filter.
//   state_e    : controller states
//   NbDx/NbDy  : 3x3 neighbourhood offsets (own cell excluded), scan order
//   cell_idx() : linear cell address from cell coordinates
package dvs_filter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StWrite,
    StOut
  } state_e;

  localparam int unsigned NumNb = 8;

  // Order (dx,dy): (-1,-1)(0,-1)(1,-1)(-1,0)(1,0)(-1,1)(0,1)(1,1)
  localparam logic signed [1:0] NbDx [NumNb] = '{
    2'sb11, 2'sb00, 2'sb01, 2'sb11, 2'sb01, 2'sb11, 2'sb00, 2'sb01
  };
  localparam logic signed [1:0] NbDy [NumNb] = '{
    2'sb11, 2'sb11, 2'sb11, 2'sb00, 2'sb00, 2'sb01, 2'sb01, 2'sb01
  };

  function automatic int unsigned cell_idx(input int unsigned cx, input int unsigned cy,
                                           input int unsigned grid_w);
    return cx + cy * grid_w;
  endfunction

endpackage

// File: rtl/dvs_bg_activity_filter_if.sv
// Address-event stream interface (valid/ready handshake).
//   valid, x, y, p, t : driven by the master
//   ready             : driven by the slave
interface dvs_bg_activity_filter_if #(
  parameter int unsigned X_W = 4,
  parameter int unsigned Y_W = 4,
  parameter int unsigned T_W = 8
);
  logic           valid;
  logic           ready;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           p;
  logic [T_W-1:0] t;

  modport master (output valid, output x, output y, output p, output t, input ready);
  modport slave  (input valid, input x, input y, input p, input t, output ready);
endinterface

// File: rtl/dvs_ts_grid.sv
// Per-cell timestamp memory for the activity filter.
//   clk, rst          : clock, synchronous active-high reset (clears valid bits)
//   flush             : single-cycle clear of all valid bits (timestamps kept)
//   rd_addr/rd_valid/rd_ts : combinational read port
//   wr_en/wr_addr/wr_ts    : synchronous write port, sets the cell valid bit
module dvs_ts_grid #(
  parameter int unsigned CELL_AW = 6,
  parameter int unsigned T_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [CELL_AW-1:0] rd_addr,
  output logic               rd_valid,
  output logic [T_W-1:0]     rd_ts,
  input  logic               wr_en,
  input  logic [CELL_AW-1:0] wr_addr,
  input  logic [T_W-1:0]     wr_ts
);
  localparam int unsigned NumCells = 1 << CELL_AW;

  logic [NumCells-1:0] valid_q, valid_d;
  logic [T_W-1:0]      ts_mem [NumCells];

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Timestamps need no reset: a cell is only consulted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ts_mem[wr_addr] <= wr_ts;
    end
  end

  assign rd_valid = valid_q[rd_addr];
  assign rd_ts    = ts_mem[rd_addr];

endmodule

// File: rtl/dvs_bg_activity_filter.sv
// Background-activity filter for address events. An event passes only if one of the
// 8 neighbouring cells (grid downsampled by DS_SHIFT) fired within cfg_dt ticks,
// using wrap-safe unsigned timestamp differences. Every accepted event refreshes
// its own cell.
//   clk, rst            : clock, synchronous active-high reset
//   in_if (slave)       : input event stream
//   out_if (master)     : filtered event stream, fields unchanged
//   cfg_dt              : inclusive correlation window, latched at accept
//   cfg_bypass          : pass all events (memory still updated), latched at accept
//   cfg_refr            : refractory period, used only with DVS_FILTER_REFRACTORY_EN
//   flush               : clear all cell valid bits (idle only, blocks accept)
//   cnt_pass, cnt_drop  : saturating event counters
// Optional feature macro: DVS_FILTER_REFRACTORY_EN drops events whose own cell fired
// less than cfg_refr ticks earlier (unless bypassed).
module dvs_bg_activity_filter
  import dvs_filter_pkg::*;
#(
  parameter int unsigned X_W      = 4,
  parameter int unsigned Y_W      = 4,
  parameter int unsigned T_W      = 8,
  parameter int unsigned DS_SHIFT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  dvs_bg_activity_filter_if.slave  in_if,
  dvs_bg_activity_filter_if.master out_if,
  input  logic [T_W-1:0]   cfg_dt,
  input  logic             cfg_bypass,
  input  logic [T_W-1:0]   cfg_refr,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt_pass,
  output logic [CNT_W-1:0] cnt_drop
);
  localparam int unsigned CX_W    = X_W - DS_SHIFT;
  localparam int unsigned CY_W    = Y_W - DS_SHIFT;
  localparam int unsigned GRID_W  = 1 << CX_W;
  localparam int unsigned CELL_AW = CX_W + CY_W;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             p_q, p_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [T_W-1:0]   dt_q, dt_d;
  logic             byp_q, byp_d;
  logic             hit_q, hit_d;
  logic             ov_q, ov_d;
  logic [X_W-1:0]   ox_q, ox_d;
  logic [Y_W-1:0]   oy_q, oy_d;
  logic             op_q, op_d;
  logic [T_W-1:0]   ot_q, ot_d;
  logic [CNT_W-1:0] cp_q, cp_d;
  logic [CNT_W-1:0] cd_q, cd_d;

  logic                   grid_flush, grid_we, rd_valid, nb_on_grid, pass;
  logic [CELL_AW-1:0]     own_addr, nb_addr, rd_addr;
  logic [T_W-1:0]         rd_ts, delta;
  logic [CX_W-1:0]        own_cx;
  logic [CY_W-1:0]        own_cy;
  logic signed [CX_W+1:0] nb_cx;
  logic signed [CY_W+1:0] nb_cy;

  assign own_cx = x_q[X_W-1:DS_SHIFT];
  assign own_cy = y_q[Y_W-1:DS_SHIFT];

  // Two guard bits: neighbour coordinate spans -1..GRID, so either top bit set means off-grid.
  assign nb_cx = $signed({2'b00, own_cx}) + (CX_W+2)'(NbDx[idx_q]);
  assign nb_cy = $signed({2'b00, own_cy}) + (CY_W+2)'(NbDy[idx_q]);
  assign nb_on_grid = ~nb_cx[CX_W+1] & ~nb_cx[CX_W] & ~nb_cy[CY_W+1] & ~nb_cy[CY_W];

  assign own_addr = CELL_AW'(cell_idx(32'(own_cx), 32'(own_cy), GRID_W));
  assign nb_addr  = CELL_AW'(cell_idx(32'(nb_cx[CX_W-1:0]), 32'(nb_cy[CY_W-1:0]), GRID_W));
  // WRITE reads its own cell (refractory check) before overwriting it.
  assign rd_addr  = (state_q == StWrite) ? own_addr : nb_addr;
  assign delta    = t_q - rd_ts;

  dvs_ts_grid #(
    .CELL_AW (CELL_AW),
    .T_W     (T_W)
  ) u_grid (
    .clk      (clk),
    .rst      (rst),
    .flush    (grid_flush),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_ts    (rd_ts),
    .wr_en    (grid_we),
    .wr_addr  (own_addr),
    .wr_ts    (t_q)
  );

`ifdef DVS_FILTER_REFRACTORY_EN
  logic refr;
  assign refr = rd_valid && (delta < cfg_refr);
  assign pass = (hit_q & ~refr) | byp_q;
`else
  logic unused_cfg_refr;
  assign unused_cfg_refr = ^cfg_refr;
  assign pass = hit_q | byp_q;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    p_d        = p_q;
    t_d        = t_q;
    dt_d       = dt_q;
    byp_d      = byp_q;
    hit_d      = hit_q;
    ov_d       = ov_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    op_d       = op_q;
    ot_d       = ot_q;
    cp_d       = cp_q;
    cd_d       = cd_q;
    grid_flush = 1'b0;
    grid_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          grid_flush = 1'b1;
        end else if (in_if.valid) begin
          x_d     = in_if.x;
          y_d     = in_if.y;
          p_d     = in_if.p;
          t_d     = in_if.t;
          dt_d    = cfg_dt;
          byp_d   = cfg_bypass;
          hit_d   = 1'b0;
          idx_d   = 3'd0;
          state_d = cfg_bypass ? StWrite : StScan;
        end
      end
      StScan: begin
        if (nb_on_grid && rd_valid && (delta <= dt_q)) begin
          hit_d = 1'b1;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        grid_we = 1'b1;
        if (pass) begin
          ov_d    = 1'b1;
          ox_d    = x_q;
          oy_d    = y_q;
          op_d    = p_q;
          ot_d    = t_q;
          state_d = StOut;
        end else begin
          if (cd_q != '1) cd_d = cd_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      StOut: begin
        if (out_if.ready) begin
          ov_d    = 1'b0;
          if (cp_q != '1) cp_d = cp_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= 1'b0;
      t_q     <= '0;
      dt_q    <= '0;
      byp_q   <= 1'b0;
      hit_q   <= 1'b0;
      ov_q    <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      op_q    <= 1'b0;
      ot_q    <= '0;
      cp_q    <= '0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      t_q     <= t_d;
      dt_q    <= dt_d;
      byp_q   <= byp_d;
      hit_q   <= hit_d;
      ov_q    <= ov_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      op_q    <= op_d;
      ot_q    <= ot_d;
      cp_q    <= cp_d;
      cd_q    <= cd_d;
    end
  end

  assign in_if.ready  = (state_q == StIdle) && !flush;
  assign out_if.valid = ov_q;
  assign out_if.x     = ox_q;
  assign out_if.y     = oy_q;
  assign out_if.p     = op_q;
  assign out_if.t     = ot_q;
  assign cnt_pass     = cp_q;
  assign cnt_drop     = cd_q;

endmodule

// File: tb/tb_dvs_bg_activity_filter.sv
// Self-checking bench for dvs_bg_activity_filter: directed scenarios followed by
// randomized events, all checked against a cell-array reference model.
module tb_dvs_bg_activity_filter;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_dt;
  logic        cfg_bypass;
  logic [7:0]  cfg_refr;
  logic        flush;
  logic [15:0] cnt_pass;
  logic [15:0] cnt_drop;

  dvs_bg_activity_filter_if #(.X_W(4), .Y_W(4), .T_W(8)) in_if ();
  dvs_bg_activity_filter_if #(.X_W(4), .Y_W(4), .T_W(8)) out_if ();

  dvs_bg_activity_filter #(
    .X_W      (4),
    .Y_W      (4),
    .T_W      (8),
    .DS_SHIFT (1),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if.slave),
    .out_if     (out_if.master),
    .cfg_dt     (cfg_dt),
    .cfg_bypass (cfg_bypass),
    .cfg_refr   (cfg_refr),
    .flush      (flush),
    .cnt_pass   (cnt_pass),
    .cnt_drop   (cnt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 8x8 cells of {valid, timestamp}; counters.
  bit         m_valid [64];
  logic [7:0] m_ts    [64];
  int         m_pass = 0;
  int         m_drop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction

  // Decide pass/drop from the filter rules, then record the event in its cell.
  function automatic bit model_event(input int x, input int y, input int t, input bit byp,
                                     input int dt, input int refr);
    int cx, cy, own;
    bit hit;
    cx  = x / 2;
    cy  = y / 2;
    own = cy * 8 + cx;
    hit = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        int nx, ny;
        nx = cx + dx;
        ny = cy + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
          if (m_valid[ny * 8 + nx] && (((t - int'(m_ts[ny * 8 + nx])) % 256 + 256) % 256) <= dt)
            hit = 1'b1;
        end
      end
    end
`ifdef DVS_FILTER_REFRACTORY_EN
    if (m_valid[own] && (((t - int'(m_ts[own])) % 256 + 256) % 256) < refr) hit = 1'b0;
`else
    if (refr < 0) hit = 1'b0;
`endif
    m_valid[own] = 1'b1;
    m_ts[own]    = 8'(t);
    return hit | byp;
  endfunction

  // Send one event, then check latency, payload, backpressure and counters.
  task automatic run_event(input int x, input int y, input int p, input int t,
                           input int hold, input bit byp);
    bit         exp_pass, bad;
    int         w, lat;
    logic [3:0] ex, ey;
    logic [7:0] et;
    logic       ep;
    w = 0;
    while (in_if.ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", in_if.ready, 1);
    ex = 4'(x); ey = 4'(y); ep = 1'(p); et = 8'(t);
    cfg_bypass  = byp;
    out_if.ready = (hold == 0);
    exp_pass = model_event(x, y, t, byp, int'(cfg_dt), int'(cfg_refr));
    in_if.valid = 1'b1;
    in_if.x = ex; in_if.y = ey; in_if.p = ep; in_if.t = et;
    @(negedge clk);
    in_if.valid = 1'b0;
    in_if.x = '0; in_if.y = '0; in_if.p = 1'b0; in_if.t = '0;
    lat = byp ? 2 : 10;
    bad = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if (out_if.valid !== 1'b0 || in_if.ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("busy_window", bad, 0);
    if (exp_pass) begin
      chk("out_valid_at_latency", out_if.valid, 1);
      chk("out_payload", {out_if.x, out_if.y, out_if.p, out_if.t}, {ex, ey, ep, et});
      bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_if.valid !== 1'b1 || {out_if.x, out_if.y, out_if.p, out_if.t} !== {ex, ey, ep, et}
            || in_if.ready !== 1'b0 || cnt_pass !== 16'(m_pass)) bad = 1'b1;
      end
      if (hold > 0) chk("backpressure_hold", bad, 0);
      out_if.ready = 1'b1;
      @(negedge clk);
      m_pass++;
      chk("out_valid_cleared", out_if.valid, 0);
      chk("cnt_pass", cnt_pass, 64'(m_pass));
      chk("ready_after_pass", in_if.ready, 1);
    end else begin
      m_drop++;
      chk("no_out_on_drop", out_if.valid, 0);
      chk("ready_after_drop", in_if.ready, 1);
      chk("cnt_drop", cnt_drop, 64'(m_drop));
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1;
    chk("ready_low_during_flush", in_if.ready, 0);
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tcur;
    rst = 1'b1;
    flush = 1'b0;
    cfg_dt = 8'd16;
    cfg_bypass = 1'b0;
    cfg_refr = 8'd8;
    in_if.valid = 1'b0;
    in_if.x = '0; in_if.y = '0; in_if.p = 1'b0; in_if.t = '0;
    out_if.ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_if.valid, 0);
    chk("reset_out_fields", {out_if.x, out_if.y, out_if.p, out_if.t}, 17'd0);
    chk("reset_counters", {cnt_pass, cnt_drop}, 32'd0);
    chk("reset_in_ready", in_if.ready, 1);

    // Isolated event
    run_event(5, 5, 1, 10, 0, 1'b0);
    chk("isolated_cnt_drop", cnt_drop, 1);
    // Correlated neighbour, delta 10
    run_event(6, 5, 1, 20, 0, 1'b0);
    chk("correlated_cnt_pass", cnt_pass, 1);
    // Window edge: delta 16 passes, delta 18 drops
    run_event(4, 5, 0, 36, 0, 1'b0);
    run_event(7, 5, 1, 54, 0, 1'b0);
    chk("window_counts", {cnt_pass, cnt_drop}, {16'd2, 16'd2});
    // Timestamp wrap
    do_flush();
    run_event(0, 0, 1, 250, 0, 1'b0);
    run_event(2, 0, 0, 4, 0, 1'b0);
    chk("wrap_cnt_pass", cnt_pass, 3);
    // Backpressure on a passing event (neighbour (3,2) at t=54 gone after flush; seed it)
    run_event(7, 5, 1, 55, 0, 1'b0);
    run_event(5, 4, 1, 60, 5, 1'b0);
    // Bypass passes an isolated event with short latency
    run_event(15, 15, 0, 100, 2, 1'b1);
`ifdef DVS_FILTER_REFRACTORY_EN
    run_event(6, 4, 1, 62, 0, 1'b0);
    run_event(6, 4, 1, 65, 0, 1'b0);
`endif

    // Reset in the middle of a scan
    in_if.valid = 1'b1;
    in_if.x = 4'd6; in_if.y = 4'd5; in_if.p = 1'b1; in_if.t = 8'd61;
    @(negedge clk);
    in_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midscan_rst_idle", in_if.ready, 1);
    chk("midscan_rst_out_valid", out_if.valid, 0);
    chk("midscan_rst_counters", {cnt_pass, cnt_drop}, 32'd0);
    rst = 1'b0;
    model_clear();
    m_pass = 0;
    m_drop = 0;
    @(negedge clk);
    run_event(6, 5, 1, 62, 0, 1'b0);
    chk("forgotten_history_drop", cnt_drop, 1);

    // Randomized traffic
    tcur = 70;
    for (int n = 0; n < 60; n++) begin
      cfg_dt = 8'($urandom_range(0, 30));
      if ($urandom_range(0, 20) == 0) do_flush();
      tcur = (tcur + int'($urandom_range(0, 12))) % 256;
      run_event(int'($urandom_range(3, 10)), int'($urandom_range(3, 10)),
                int'($urandom_range(0, 1)), tcur, int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0));
    end
    chk("final_cnt_pass", cnt_pass, 64'(m_pass));
    chk("final_cnt_drop", cnt_drop, 64'(m_drop));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
